substitute_serial: RTL and testbench
====================================

# substitute_serial

Parametrised SubBytes/InvSubBytes engine for the AES datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes all 16 bytes. It uses LANES byte lanes, time-multiplexed over 16/LANES beats, so area can be traded against latency. A per-transaction mode bit selects the forward or inverse S-box, so one instance serves both the encrypt and decrypt round paths.

## Interface
- LANES, default 4: number of parallel byte lanes. Legal values are 1, 2, 4, 8 and 16; any other value is a elaboration error.
- BEATS, derived as 16/LANES: cycles per block. Not overridable.
- clk  input  1  rising-edge clock.
- n_rst  input  1  reset. One clock; reset is synchronous and active-low.
- in_valid  input  1  data_in and inv_mode are valid.
- in_ready  output  1  block can accept a new state.
- data_in  input  128  state to substitute. Byte 0 is [127:120].
- inv_mode  input  1  0 = forward S-box, 1 = inverse S-box. Sampled on accept.
- out_valid  output  1  data_out holds a complete result.
- out_ready  input  1  downstream accepts the result.
- data_out  output  128  substituted state, same byte ordering as data_in.
- busy  output  1  high in BUSY.

## Operation
- State machine: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid: latch data_in into in_reg, latch inv_mode into mode_reg, clear beat counter, go to BUSY.
  - BUSY: each cycle, lanes process bytes beat*LANES through beat*LANES+LANES-1, taken from in_reg, MSB byte first.
    - Each lane instantiates one SBox and one InvSBox. Both are combinational 8-bit modules.
    - mode_reg selects which result is written into the matching bytes of out_reg.
    - The counter increments each cycle. When the counter reaches BEATS-1, go to DONE.
  - DONE: out_valid=1, data_out=out_reg. On out_ready, go to IDLE.
- Counter width is max(1, clog2(BEATS)). The counter never wraps inside a block; it is cleared on accept.
- in_ready is decoded from state only. It is low in BUSY and DONE; no overlap of input accept and output hold.
- in_valid and data_in changes while not in IDLE are ignored. in_reg and mode_reg are stable for the whole block.
- data_out holds its last value after the handshake until the next block's writes overwrite it.
- Bytes of out_reg not yet written in the current block keep their previous values. data_out is only meaningful when out_valid=1.

## Timing
- Reset: a synchronous reset at any clock edge with n_rst=0 forces the following, overriding all other events:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - data_out=0, counter=0, in_reg=0, mode_reg=0
- Reset mid-operation: BUSY or DONE work is discarded and no out_valid pulse is produced.
- Latency: accept on edge T. out_valid=1 from edge T+BEATS (LANES=16 gives 1 cycle; LANES=1 gives 16 cycles). out_valid stays high until the edge where out_ready=1.
- Minimum issue interval is BEATS+2 cycles: accept, BEATS busy cycles, the DONE handshake cycle, and the return to IDLE.
- out_ready=1 already asserted on entry to DONE: the handshake completes on the first DONE cycle and out_valid is high for exactly one cycle.
- Throughput is one block per BEATS+2 cycles with out_ready tied high.

## Test plan
- Reset, then hold n_rst=1 idle: in_ready=1, out_valid=0, data_out=0.
- LANES=4, forward mode, data_in=193de3bea0f4e22b9ac68d2ae9f84808 -> after 4 cycles data_out=d42711aee0bf98f1b8b45de51e415230, out_valid=1.
- LANES=1, inverse mode, data_in=d42711aee0bf98f1b8b45de51e415230 -> after 16 cycles data_out=193de3bea0f4e22b9ac68d2ae9f84808.
- LANES=16, forward mode, data_in all 00, then all ff with out_ready tied 1:
  - First block -> data_out=6363…63 one cycle after accept.
  - Second block -> data_out=1616…16.
  - Blocks accepted every 3 cycles.
- Back-pressure: out_ready=0 for 10 cycles after out_valid; toggle in_valid and data_in meanwhile -> data_out stable, in_ready=0, no new accept.
- Reset asserted in the 2nd BUSY cycle (LANES=2) -> next cycle IDLE, data_out=0, and out_valid never rises for the aborted block.

Source files
------------

// File: rtl/substitute_serial.sv
// ============================================================================
// Module   : substitute_serial
// Purpose  : Time-multiplexed AES SubBytes / InvSubBytes over LANES byte lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package substitute_serial_pkg;
    localparam logic [7:0] C_INV_EXP = 8'd254;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (C_INV_EXP[i]) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction
endpackage

module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import substitute_serial_pkg::*;
    logic [7:0] w_inv;
    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3)
                    ^ rotl8(w_inv, 4) ^ 8'h63;
endmodule

module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import substitute_serial_pkg::*;
    logic [7:0] w_aff;
    assign w_aff  = rotl8(i_byte, 1) ^ rotl8(i_byte, 3) ^ rotl8(i_byte, 6) ^ 8'h05;
    assign o_byte = gf_inv(w_aff);
endmodule

module substitute_serial #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         inv_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] C_LAST      = CW'(BEATS - 1);
    localparam logic [127:0]  C_LANE_MASK = ~({128{1'b1}} >> (8 * LANES));

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("substitute_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [127:0]     r_in_reg;
    logic [127:0]     r_out_reg;
    logic             r_mode;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [7:0]         w_shift;
    logic [127:0]       w_window;
    logic [8*LANES-1:0] w_lane_res;
    logic [127:0]       w_res;
    logic [127:0]       w_mask;

    // Shifting the input left brings the current beat's bytes to the top of the word
    assign w_shift  = 8'(r_cnt) * 8'(LANES * 8);
    assign w_window = r_in_reg << w_shift;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] w_fwd;
        logic [7:0] w_inv;
        sbox u_sbox (
            .i_byte (w_window[127-8*l -: 8]),
            .o_byte (w_fwd)
        );
        inv_sbox u_inv_sbox (
            .i_byte (w_window[127-8*l -: 8]),
            .o_byte (w_inv)
        );
        assign w_lane_res[8*LANES-1-8*l -: 8] = r_mode ? w_inv : w_fwd;
    end

    assign w_res  = (128'(w_lane_res) << (128 - 8 * LANES)) >> w_shift;
    assign w_mask = C_LANE_MASK >> w_shift;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_reg    <= '0;
            r_out_reg   <= '0;
            r_mode      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_reg   <= data_in;
                        r_mode     <= inv_mode;
                        r_cnt      <= '0;
                        r_state    <= S_BUSY;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_out_reg <= (r_out_reg & ~w_mask) | w_res;
                    if (r_cnt == C_LAST) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_out_reg;

endmodule

`default_nettype wire

// File: tb/tb_substitute_serial.sv
// ============================================================================
// Module   : tb_substitute_serial
// Purpose  : Directed vector bench over four LANES configurations (4, 1, 16, 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_substitute_serial;
    logic         clk = 1'b0;
    logic         n_rst;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [127:0] data_in   [4];
    logic         inv_mode  [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [127:0] data_out  [4];
    logic         busy      [4];

    int n_vec  = 0;
    int n_fail = 0;
    int beats_of [4] = '{4, 16, 1, 8};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 2;
        substitute_serial #(.LANES(L)) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in[g]),
            .inv_mode  (inv_mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        int           d;
        logic         inv;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_block(input int d, input logic inv, input logic [127:0] din,
                             input logic [127:0] exp, input string nm);
        int n;
        @(negedge clk);
        chk({nm, " in_ready before accept"}, 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1;
        data_in[d]  = din;
        inv_mode[d] = inv;
        @(posedge clk); #1;
        // Scramble inputs after accept: the DUT must use its latched copies
        in_valid[d] = 1'b0;
        data_in[d]  = ~din;
        inv_mode[d] = ~inv;
        chk({nm, " busy after accept"}, 128'(busy[d]), 128'd1);
        chk({nm, " in_ready after accept"}, 128'(in_ready[d]), 128'd0);
        n = 0;
        while (!out_valid[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 128'(n), 128'(beats_of[d]));
        chk({nm, " data_out"}, data_out[d], exp);
        @(posedge clk); #1;
        chk({nm, " out_valid after handshake"}, 128'(out_valid[d]), 128'd0);
        chk({nm, " data_out held"}, data_out[d], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_hold;
        logic         seen;
        int           n;

        vecs[0] = '{0, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[1] = '{1, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[2] = '{2, 1'b0, {16{8'h00}}, {16{8'h63}}};
        vecs[3] = '{2, 1'b0, {16{8'hff}}, {16{8'h16}}};
        vecs[4] = '{3, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
        vecs[5] = '{3, 1'b1, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[6] = '{0, 1'b1, {16{8'h63}}, {16{8'h00}}};
        vecs[7] = '{1, 1'b0, {16{8'h53}}, {16{8'hed}}};

        n_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            data_in[i]   = '0;
            inv_mode[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset in_ready[%0d]", i), 128'(in_ready[i]), 128'd1);
            chk($sformatf("reset out_valid[%0d]", i), 128'(out_valid[i]), 128'd0);
            chk($sformatf("reset busy[%0d]", i), 128'(busy[i]), 128'd0);
            chk($sformatf("reset data_out[%0d]", i), data_out[i], 128'd0);
        end

        for (int v = 0; v < 8; v++) begin
            run_block(vecs[v].d, vecs[v].inv, vecs[v].din, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Back-to-back issue on LANES=16 with in_valid and out_ready held high
        @(negedge clk);
        in_valid[2] = 1'b1; data_in[2] = {16{8'h00}}; inv_mode[2] = 1'b0;
        @(posedge clk); #1;
        data_in[2] = {16{8'hff}};
        chk("tput busy A", 128'(busy[2]), 128'd1);
        @(posedge clk); #1;
        chk("tput out_valid A", 128'(out_valid[2]), 128'd1);
        chk("tput data A", data_out[2], {16{8'h63}});
        @(posedge clk); #1;
        chk("tput idle gap valid", 128'(out_valid[2]), 128'd0);
        chk("tput idle gap ready", 128'(in_ready[2]), 128'd1);
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        chk("tput busy B", 128'(busy[2]), 128'd1);
        @(posedge clk); #1;
        chk("tput out_valid B", 128'(out_valid[2]), 128'd1);
        chk("tput data B", data_out[2], {16{8'h16}});
        @(posedge clk); #1;
        chk("tput end valid", 128'(out_valid[2]), 128'd0);

        // Back-pressure on LANES=4
        exp_hold = 128'hd42711aee0bf98f1b8b45de51e415230;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b1; data_in[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; inv_mode[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp latency", 128'(n), 128'd4);
        chk("bp data", data_out[0], exp_hold);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid[0] = i[0] ? 1'b0 : 1'b1;
            data_in[0]  = {$urandom, $urandom, $urandom, $urandom};
            inv_mode[0] = i[1];
            @(posedge clk); #1;
            chk($sformatf("bp hold valid c%0d", i), 128'(out_valid[0]), 128'd1);
            chk($sformatf("bp hold ready c%0d", i), 128'(in_ready[0]), 128'd0);
            chk($sformatf("bp hold data c%0d", i), data_out[0], exp_hold);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp release valid", 128'(out_valid[0]), 128'd0);
        chk("bp release ready", 128'(in_ready[0]), 128'd1);
        chk("bp release data", data_out[0], exp_hold);

        // Reset during the second BUSY cycle on LANES=2
        @(negedge clk);
        in_valid[3] = 1'b1; data_in[3] = 128'h000102030405060708090a0b0c0d0e0f; inv_mode[3] = 1'b0;
        @(posedge clk); #1;
        in_valid[3] = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(posedge clk); #1;
        chk("abort in_ready", 128'(in_ready[3]), 128'd1);
        chk("abort busy", 128'(busy[3]), 128'd0);
        chk("abort out_valid", 128'(out_valid[3]), 128'd0);
        chk("abort data_out", data_out[3], 128'd0);
        n_rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid[3]) seen = 1'b1;
        end
        chk("abort no out_valid", 128'(seen), 128'd0);
        run_block(3, 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76, "post-abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
